ysyx_040066_mdu_ctrl: RTL

Sequencer for the shared iterative multiply/divide unit (MDU) used by EX-stage M-extension instructions (ALUctr[5]=1). It latches the operands and pre-extends them, and handles divide-by-zero and signed overflow itself. It issues a start/ready handshake to the MDU, waits for completion, then holds the formatted result until downstream accepts. Its stall output feeds the pipeline block chain, keeping EX frozen while the instruction is in flight.

---
 rtl/ysyx_040066_mdu_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_040066_mdu_ctrl.sv
// ysyx_040066_mdu_ctrl
//   This module sequences one EX-stage M-extension instruction through the
//   shared iterative multiply/divide unit (MDU). It latches and pre-extends
//   the operands. Divide-by-zero and signed overflow can complete locally
//   without starting the MDU. The formatted result is held until downstream
//   accepts it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_op/in_word   instruction request (funct3, *W variant)
//   in_src1, in_src2         raw operands
//   flush                    kill the in-flight op (highest priority)
//   out_ready                downstream accepts the result
//   stall                    hold EX and upstream stages
//   out_valid, out_result    final rd value handshake
//   u_start/u_ready          MDU request handshake
//   u_is_div, u_signed_a/b   MDU operation controls
//   u_a, u_b                 extended operands to the MDU
//   u_flush                  one-cycle MDU abort
//   u_done, u_lo, u_hi       MDU completion pulse and result halves
module ysyx_040066_mdu_ctrl #(
    parameter int unsigned XLEN         = 64,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    input  logic            out_ready,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            u_start,
    input  logic            u_ready,
    output logic            u_is_div,
    output logic            u_signed_a,
    output logic            u_signed_b,
    output logic [XLEN-1:0] u_a,
    output logic [XLEN-1:0] u_b,
    output logic            u_flush,
    input  logic            u_done,
    input  logic [XLEN-1:0] u_lo,
    input  logic [XLEN-1:0] u_hi
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;

    // MULH, MULHSU, DIV, REM treat the first operand as signed
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    endfunction

    // MULH, DIV, REM treat the second operand as signed
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    endfunction

    function automatic logic [XLEN-1:0] extend32(input logic [XLEN-1:0] v, input logic sgn);
        return {{(XLEN-32){sgn & v[31]}}, v[31:0]};
    endfunction

    // Word ops always write back a sign-extended 32-bit value
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] r, input logic word);
        return word ? extend32(r, 1'b1) : r;
    endfunction

    logic [XLEN-1:0] ext_a, ext_b, special_res;
    logic            div_zero, div_ovf;

    always_comb begin
        ext_a    = in_word ? extend32(in_src1, op_signed_a(in_op)) : in_src1;
        ext_b    = in_word ? extend32(in_src2, op_signed_b(in_op)) : in_src2;
        div_zero = in_op[2] && (ext_b == '0);
        div_ovf  = in_op[2] && !in_op[0] && !in_word && (ext_a == SMIN) && (ext_b == '1);
        // in_op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) begin
            special_res = in_op[1] ? ext_a : '1;
        end else begin
            special_res = in_op[1] ? '0 : ext_a;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        word_d  = word_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = in_op;
                    word_d = in_word;
                    a_d    = ext_a;
                    b_d    = ext_b;
                    if (FAST_SPECIAL && (div_zero || div_ovf)) begin
                        res_d   = fmt(special_res, in_word);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (u_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (u_done) begin
                    // MUL and DIV/DIVU take the low half; MULH* and REM* the high half
                    if (op_q == 3'b000 || (op_q[2] && !op_q[1])) begin
                        res_d = fmt(u_lo, word_q);
                    end else begin
                        res_d = fmt(u_hi, word_q);
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush overrides every other event; a latched request in IDLE is
        // dropped too since the redirect kills the instruction
        if (flush) begin
            state_d = S_IDLE;
            op_d    = op_q;
            word_d  = word_q;
            a_d     = a_q;
            b_d     = b_q;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            word_q  <= word_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // All outputs are forced low while reset is asserted
    always_comb begin
        stall      = !rst && ((state_q == S_IDLE && in_valid) || state_q == S_ISSUE ||
                              state_q == S_WAIT || (state_q == S_DONE && !out_ready));
        out_valid  = !rst && (state_q == S_DONE);
        out_result = out_valid ? res_q : '0;
        u_start    = !rst && (state_q == S_ISSUE);
        u_is_div   = !rst && op_q[2];
        u_signed_a = !rst && op_signed_a(op_q);
        u_signed_b = !rst && op_signed_b(op_q);
        u_a        = rst ? '0 : a_q;
        u_b        = rst ? '0 : b_q;
        u_flush    = !rst && flush && (state_q == S_ISSUE || state_q == S_WAIT);
    end

endmodule
